// File: rtl/pos_counter_if.sv
// Motor position counter bus: raw sensor, renormalise request and the two counts.
interface pos_counter_if;
    logic        sensor;
    logic        subtract;
    logic [15:0] distance;
    logic [15:0] pos1;
    logic [15:0] pos2;

    modport master (
        output sensor,
        output subtract,
        output distance,
        input  pos1,
        input  pos2
    );

    modport slave (
        input  sensor,
        input  subtract,
        input  distance,
        output pos1,
        output pos2
    );
endinterface

// File: rtl/pos_counter.sv
// Counts rising edges of an asynchronous motor sensor into an absolute count (pos1)
// and a relative count (pos2) that the parent renormalises with subtract/distance.
module pos_counter (
    input  logic        clk,
    input  logic [1:0]  clear,
    pos_counter_if.slave bus
);

    logic        s1_q, s2_q, s3_q;
    logic [15:0] pos1_q, pos1_d;
    logic [15:0] pos2_q, pos2_d;
    logic        inc;
    logic [15:0] inc_w;

    always_comb begin
        inc    = s2_q & ~s3_q;
        inc_w  = {15'd0, inc};
        pos1_d = pos1_q + inc_w;
        // Subtract and increment land in the same cycle so no pulse is lost.
        if (bus.subtract) begin
            pos2_d = pos2_q - bus.distance + inc_w;
        end else begin
            pos2_d = pos2_q + inc_w;
        end
    end

    always_ff @(posedge clk) begin
        if (clear != 2'b00) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            pos1_q <= 16'h0000;
            pos2_q <= 16'h0000;
        end else begin
            s1_q   <= bus.sensor;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pos1_q <= pos1_d;
            pos2_q <= pos2_d;
        end
    end

    assign bus.pos1 = pos1_q;
    assign bus.pos2 = pos2_q;

endmodule

// File: tb/tb_pos_counter.sv
// Directed bench for pos_counter: one bench-driven instance plus a pair wired like the parent.
module tb_pos_counter;

    logic        clk;
    logic [1:0]  clear;
    logic [1:0]  clear_par;
    logic        sensor_par;
    logic [15:0] par_dist;
    int          checks;
    int          errors;
    int          par_viol;
    logic        par_active;
    logic        par_seen_top;

    pos_counter_if dut_if ();
    pos_counter_if par_a_if ();
    pos_counter_if par_b_if ();

    pos_counter u_dut (
        .clk   (clk),
        .clear (clear),
        .bus   (dut_if)
    );

    pos_counter u_par_a (
        .clk   (clk),
        .clear (clear_par),
        .bus   (par_a_if)
    );

    pos_counter u_par_b (
        .clk   (clk),
        .clear (clear_par),
        .bus   (par_b_if)
    );

    // Parent wiring: any pos2 reaching bit 15 renormalises both by the smaller pos2.
    assign par_dist          = (par_a_if.pos2 < par_b_if.pos2) ? par_a_if.pos2 : par_b_if.pos2;
    assign par_a_if.subtract = par_a_if.pos2[15] | par_b_if.pos2[15];
    assign par_b_if.subtract = par_a_if.pos2[15] | par_b_if.pos2[15];
    assign par_a_if.distance = par_dist;
    assign par_b_if.distance = par_dist;
    assign par_a_if.sensor   = sensor_par;
    assign par_b_if.sensor   = sensor_par;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (par_active) begin
            if (par_a_if.pos2 > 16'h8000 || par_a_if.pos2 != par_b_if.pos2 ||
                par_a_if.pos1 != par_b_if.pos1) begin
                par_viol = par_viol + 1;
            end
            if (par_a_if.pos2 == 16'h8000) begin
                par_seen_top = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        dut_if.sensor = 1'b1;
        tick();
        dut_if.sensor = 1'b0;
        tick();
    endtask

    logic [15:0] toggle_exp [6];

    initial begin
        checks          = 0;
        errors          = 0;
        par_viol        = 0;
        par_active      = 1'b0;
        par_seen_top    = 1'b0;
        clear           = 2'b01;
        clear_par       = 2'b01;
        sensor_par      = 1'b0;
        dut_if.sensor   = 1'b0;
        dut_if.subtract = 1'b0;
        dut_if.distance = 16'h0000;
        toggle_exp      = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};

        // Clear with sensor low; counts stay at zero.
        tick();
        clear = 2'b00;
        check_val("reset_pos1", dut_if.pos1, 16'h0000);
        check_val("reset_pos2", dut_if.pos2, 16'h0000);
        ticks(4);
        check_val("idle_pos1", dut_if.pos1, 16'h0000);
        check_val("idle_pos2", dut_if.pos2, 16'h0000);

        // 1,0,1,0,1,0 toggling: increments appear two edges after sampling.
        for (int i = 0; i < 6; i++) begin
            dut_if.sensor = (i % 2 == 0);
            tick();
            check_val($sformatf("toggle_pos1_%0d", i), dut_if.pos1, toggle_exp[i]);
        end
        ticks(3);
        check_val("toggle_pos1", dut_if.pos1, 16'd3);
        check_val("toggle_pos2", dut_if.pos2, 16'd3);

        // Renormalise by 3 with no edges in flight.
        dut_if.subtract = 1'b1;
        dut_if.distance = 16'd3;
        tick();
        dut_if.subtract = 1'b0;
        dut_if.distance = 16'd0;
        check_val("sub_pos2", dut_if.pos2, 16'd0);
        check_val("sub_pos1", dut_if.pos1, 16'd3);

        // Bring pos2 to 10, then subtract 4 in the same cycle as an inc pulse.
        for (int i = 0; i < 10; i++) pulse();
        ticks(2);
        check_val("ten_pos2", dut_if.pos2, 16'd10);
        check_val("ten_pos1", dut_if.pos1, 16'd13);
        dut_if.sensor = 1'b1;
        tick();
        dut_if.sensor = 1'b0;
        tick();
        dut_if.subtract = 1'b1;
        dut_if.distance = 16'd4;
        tick();
        dut_if.subtract = 1'b0;
        dut_if.distance = 16'd0;
        check_val("subinc_pos2", dut_if.pos2, 16'd7);
        check_val("subinc_pos1", dut_if.pos1, 16'd14);
        ticks(3);
        check_val("subinc_hold_pos2", dut_if.pos2, 16'd7);

        // Static high counts once; falling edge and static low count nothing.
        dut_if.sensor = 1'b1;
        ticks(6);
        check_val("high_pos1", dut_if.pos1, 16'd15);
        check_val("high_pos2", dut_if.pos2, 16'd8);
        dut_if.sensor = 1'b0;
        ticks(6);
        check_val("low_pos1", dut_if.pos1, 16'd15);
        check_val("low_pos2", dut_if.pos2, 16'd8);

        // Underflow wraps modulo 2^16, and so does the following increment.
        dut_if.subtract = 1'b1;
        dut_if.distance = 16'd9;
        tick();
        dut_if.subtract = 1'b0;
        dut_if.distance = 16'd0;
        check_val("wrap_pos2", dut_if.pos2, 16'hFFFF);
        check_val("wrap_pos1", dut_if.pos1, 16'd15);
        pulse();
        tick();
        check_val("wrap_inc_pos2", dut_if.pos2, 16'h0000);
        check_val("wrap_inc_pos1", dut_if.pos1, 16'd16);

        // Clear 2'b11 while an inc pulse is pending, also asking for a subtract.
        dut_if.sensor = 1'b1;
        tick();
        dut_if.sensor = 1'b0;
        tick();
        clear           = 2'b11;
        dut_if.subtract = 1'b1;
        dut_if.distance = 16'd5;
        tick();
        clear           = 2'b00;
        dut_if.subtract = 1'b0;
        dut_if.distance = 16'd0;
        check_val("clr11_pos1", dut_if.pos1, 16'h0000);
        check_val("clr11_pos2", dut_if.pos2, 16'h0000);
        ticks(4);
        check_val("clr11_drop_pos1", dut_if.pos1, 16'h0000);
        check_val("clr11_drop_pos2", dut_if.pos2, 16'h0000);

        // Clear 2'b10 with sensor already high: counts as one edge afterwards.
        dut_if.sensor = 1'b1;
        ticks(3);
        check_val("pre_clr10_pos1", dut_if.pos1, 16'd1);
        clear = 2'b10;
        tick();
        clear = 2'b00;
        check_val("clr10_pos1", dut_if.pos1, 16'h0000);
        ticks(2);
        check_val("clr10_lat_pos1", dut_if.pos1, 16'h0000);
        tick();
        check_val("clr10_high_pos1", dut_if.pos1, 16'd1);
        check_val("clr10_high_pos2", dut_if.pos2, 16'd1);
        dut_if.sensor = 1'b0;

        // Parent-wired pair: 32768 + 16 common pulses.
        clear_par = 2'b00;
        tick();
        par_active = 1'b1;
        for (int i = 0; i < 32784; i++) begin
            sensor_par = 1'b1;
            tick();
            sensor_par = 1'b0;
            tick();
        end
        ticks(4);
        par_active = 1'b0;
        check_val("par_a_pos2", par_a_if.pos2, 16'd16);
        check_val("par_b_pos2", par_b_if.pos2, 16'd16);
        check_val("par_a_pos1", par_a_if.pos1, 16'h8010);
        check_val("par_b_pos1", par_b_if.pos1, 16'h8010);
        check_val("par_violations", 16'(par_viol), 16'd0);
        check_val("par_reached_8000", {15'd0, par_seen_top}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
